// File: rtl/mul_sequencer.sv
// Iterative 32-cycle shift-add multiplier for the RV32M MUL instruction.
// Holds the pipeline stall line while the loop runs and pulses done with the low product.
module mul_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instruction,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           accept;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   acc_next;
  logic [CW-1:0]  count_q;
  logic           last_iter;
  logic           unused_instr_bits;

  // Only the R-type MUL encoding (funct7=1, funct3=0) starts a multiply.
  assign accept = start
               && (instruction[6:0]   == 7'b0110011)
               && (instruction[31:25] == 7'b0000001)
               && (instruction[14:12] == 3'b000);

  assign unused_instr_bits = ^{instruction[24:15], instruction[11:7]};

  assign acc_next  = acc_q + (b_q[0] ? a_q : W'(0));
  assign last_iter = (count_q == CW'(W - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RUN;
      S_RUN:   if (last_iter) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode; stall must rise in the accept cycle itself
  always_comb begin
    stall = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_IDLE:  stall = accept;
      S_RUN: begin
        stall = 1'b1;
        busy  = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Shift-add datapath; result is loaded on the last iteration so it is valid during DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
      result  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q     <= operand_a;
            b_q     <= operand_b;
            acc_q   <= '0;
            count_q <= '0;
          end
        end
        S_RUN: begin
          acc_q   <= acc_next;
          a_q     <= a_q << 1;
          b_q     <= b_q >> 1;
          count_q <= count_q + CW'(1);
          if (last_iter) result <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized scoreboard bench for mul_sequencer: a cycle-timeline model predicts
// stall/busy/done and queues expected products that the monitor pops on done.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instruction;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  localparam logic [31:0] MUL_I  = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
  localparam logic [31:0] ADD_I  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
  localparam logic [31:0] MULH_I = {7'b0000001, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011};

  mul_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instruction (instruction),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks   = 0;
  int          failures = 0;
  bit          chk_en   = 1'b0;
  bit          running  = 1'b0;
  int          acc_t    = 0;
  logic [31:0] exp_result = '0;
  logic [31:0] sb_q[$];

  function automatic bit is_mul(logic [31:0] i);
    return (i[6:0] == 7'b0110011) && (i[31:25] == 7'b0000001) && (i[14:12] == 3'b000);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Model: a MUL accepted in cycle T runs T+1..T+32 and completes in T+33.
  always @(negedge clk) begin
    bit in_run, in_done, acc_now;
    in_run  = running && (cyc >= acc_t + 1) && (cyc <= acc_t + 32);
    in_done = running && (cyc == acc_t + 33);
    acc_now = start && is_mul(instruction) && !in_run && !in_done;
    if (chk_en) begin
      check("stall", 32'(stall), 32'(acc_now || in_run));
      check("busy",  32'(busy),  32'(in_run));
      check("done",  32'(done),  32'(in_done));
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty cycle=%0d actual=done expected=no_done", cyc);
        end else begin
          exp_result = sb_q.pop_front();
        end
      end
      check("result", result, exp_result);
    end
    if (in_done) running = 1'b0;
    if (reset) begin
      running    = 1'b0;
      sb_q.delete();
      exp_result = '0;
    end else if (acc_now) begin
      running = 1'b1;
      acc_t   = cyc;
      sb_q.push_back(operand_a * operand_b);
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(logic [31:0] ins, logic [31:0] a, logic [31:0] b);
    start       = 1'b1;
    instruction = ins;
    operand_a   = a;
    operand_b   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    instruction = '0;
    operand_a   = '0;
    operand_b   = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(2);

    issue(MUL_I, 32'd7, 32'd6);                 idle(34);
    issue(MUL_I, 32'hFFFFFFFF, 32'hFFFFFFFF);   idle(34);
    issue(MUL_I, 32'h80000000, 32'd2);          idle(34);

    issue(ADD_I, 32'd5, 32'd5);                 idle(2);
    issue(MULH_I, 32'd5, 32'd5);                idle(3);

    // Starts at T+10 (mid-run) and T+33 (DONE) must be dropped
    issue(MUL_I, 32'd3, 32'd5);                 idle(9);
    issue(MUL_I, 32'd9, 32'd9);                 idle(22);
    issue(MUL_I, 32'd9, 32'd9);                 idle(40);

    issue(MUL_I, 32'd100, 32'd100);             idle(11);
    pulse_reset();                              idle(40);
    issue(MUL_I, 32'd2, 32'd3);                 idle(34);

    issue(MUL_I, 32'h1234, 32'h10);             idle(33);
    issue(MUL_I, 32'hFFFF, 32'h10001);          idle(34);

    // Reset coincident with an accept: reset wins
    reset = 1'b1;
    issue(MUL_I, 32'd11, 32'd13);
    reset = 1'b0;
    idle(3);

    for (int k = 0; k < 30; k++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      case (kind)
        6:       issue(ADD_I, $urandom, $urandom);
        7:       issue(MULH_I, $urandom, $urandom);
        8:       issue($urandom, $urandom, $urandom);
        9: begin
          reset = 1'b1;
          issue(MUL_I, $urandom, $urandom);
          reset = 1'b0;
        end
        default: issue(MUL_I, $urandom, $urandom);
      endcase
      idle(int'($urandom_range(0, 40)));
    end

    idle(40);
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
